// File: rtl/dcache_ctrl_mem_if.sv
// Bus bundles for the MEM-stage data cache.
// dcache_cpu_if: pipeline (master) to cache (slave) load/store port.
// dcache_mem_if: cache (master) to data memory (slave) line port.
// Signal suffixes are relative to the cache: _i flows into it, _o flows out of it.

interface dcache_cpu_if;
    logic        cpu_MemRead_i;
    logic        cpu_MemWrite_i;
    logic [31:0] cpu_addr_i;
    logic [31:0] cpu_data_i;
    logic [31:0] cpu_data_o;
    logic        cpu_stall_o;

    modport master (
        output cpu_MemRead_i, cpu_MemWrite_i, cpu_addr_i, cpu_data_i,
        input  cpu_data_o, cpu_stall_o
    );

    modport slave (
        input  cpu_MemRead_i, cpu_MemWrite_i, cpu_addr_i, cpu_data_i,
        output cpu_data_o, cpu_stall_o
    );
endinterface

interface dcache_mem_if #(
    parameter int LINE_W = 256
);
    logic [LINE_W-1:0] mem_data_i;
    logic              mem_ack_i;
    logic              mem_enable_o;
    logic              mem_write_o;
    logic [31:0]       mem_addr_o;
    logic [LINE_W-1:0] mem_data_o;

    modport master (
        input  mem_data_i, mem_ack_i,
        output mem_enable_o, mem_write_o, mem_addr_o, mem_data_o
    );

    modport slave (
        output mem_data_i, mem_ack_i,
        input  mem_enable_o, mem_write_o, mem_addr_o, mem_data_o
    );
endinterface

// File: rtl/dcache_ctrl_mem.sv
// MEM-stage L1 data cache: direct-mapped, write-back, write-allocate.
// Hits (load or store) complete with no stall; a miss freezes the pipeline
// while an optional dirty-line eviction and a line refill run over the
// 256-bit memory port. Tag/line storage is read combinationally because the
// hit decision and load data must be available in the same cycle.

module dcache_ctrl_mem #(
    parameter int INDEX_W = 4,
    parameter int LINE_W  = 256,
    parameter int TAG_W   = 32 - INDEX_W - 5
) (
    input  logic         clk_i,
    input  logic         rst_i,
    dcache_cpu_if.slave  cpu,
    dcache_mem_if.master mem
);
    localparam int NUM_SETS = 1 << INDEX_W;
    localparam int OFF_W    = 5;
    localparam int WORDS    = LINE_W / 32;
    localparam int WSEL_W   = $clog2(WORDS);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        ALLOCATE  = 2'd2
    } state_t;

    state_t state_q, state_d;

    // Per-set storage; tags and lines are never reset, only valid/dirty are.
    logic [TAG_W-1:0]    tag_mem  [NUM_SETS];
    logic [LINE_W-1:0]   line_mem [NUM_SETS];
    logic [NUM_SETS-1:0] valid_vec;
    logic [NUM_SETS-1:0] dirty_vec;

    // Address fields, sampled straight from the EX/MEM register every cycle.
    logic [TAG_W-1:0]   addr_tag;
    logic [INDEX_W-1:0] addr_idx;
    logic [WSEL_W-1:0]  addr_word;
    logic               unused_addr_bits;

    assign addr_tag         = cpu.cpu_addr_i[31 -: TAG_W];
    assign addr_idx         = cpu.cpu_addr_i[OFF_W +: INDEX_W];
    assign addr_word        = cpu.cpu_addr_i[2 +: WSEL_W];
    assign unused_addr_bits = ^cpu.cpu_addr_i[1:0];

    // Currently addressed set.
    logic [TAG_W-1:0]  cur_tag;
    logic [LINE_W-1:0] cur_line;
    logic              cur_valid;
    logic              cur_dirty;
    logic              req;
    logic              hit;

    assign cur_tag   = tag_mem[addr_idx];
    assign cur_line  = line_mem[addr_idx];
    assign cur_valid = valid_vec[addr_idx];
    assign cur_dirty = dirty_vec[addr_idx];
    assign req       = cpu.cpu_MemRead_i | cpu.cpu_MemWrite_i;
    assign hit       = cur_valid & (cur_tag == addr_tag);

    // Store hits only update the array from IDLE; during a miss the set
    // being refilled cannot hit anyway, this just keeps the intent explicit.
    logic store_en;
    logic fill_en;
    logic wb_done;

    assign store_en = (state_q == IDLE) & hit & cpu.cpu_MemWrite_i;

    // Split the addressed line into words and build the store-merged line.
    logic [31:0]       line_words [WORDS];
    logic [LINE_W-1:0] store_line;

    genvar gi;
    for (gi = 0; gi < WORDS; gi++) begin : g_word
        assign line_words[gi]          = cur_line[32*gi +: 32];
        assign store_line[32*gi +: 32] = (addr_word == WSEL_W'(gi)) ? cpu.cpu_data_i
                                                                     : line_words[gi];
    end

    // Per-set valid/dirty flags with their own next-state logic.
    for (gi = 0; gi < NUM_SETS; gi++) begin : g_set
        logic valid_q, valid_d;
        logic dirty_q, dirty_d;
        logic set_sel;

        assign set_sel = (addr_idx == INDEX_W'(gi));

        // A fill validates and cleans the set, an eviction cleans it, a store hit dirties it.
        always_comb begin
            valid_d = valid_q;
            dirty_d = dirty_q;
            if (set_sel) begin
                if (fill_en) begin
                    valid_d = 1'b1;
                    dirty_d = 1'b0;
                end else if (wb_done) begin
                    dirty_d = 1'b0;
                end else if (store_en) begin
                    dirty_d = 1'b1;
                end
            end
        end

        // Flag registers, cleared by reset so the whole cache reads as empty.
        always_ff @(posedge clk_i or negedge rst_i) begin
            if (!rst_i) begin
                valid_q <= 1'b0;
                dirty_q <= 1'b0;
            end else begin
                valid_q <= valid_d;
                dirty_q <= dirty_d;
            end
        end

        assign valid_vec[gi] = valid_q;
        assign dirty_vec[gi] = dirty_q;
    end

    // Tag/line array writes: refill replaces the whole line, a store hit one word.
    always_ff @(posedge clk_i) begin
        if (fill_en) begin
            line_mem[addr_idx] <= mem.mem_data_i;
            tag_mem[addr_idx]  <= addr_tag;
        end else if (store_en) begin
            line_mem[addr_idx] <= store_line;
        end
    end

    // Miss-handling state register; reset abandons any in-flight transaction.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    logic              mem_enable;
    logic              mem_write;
    logic [31:0]       mem_addr;
    logic [LINE_W-1:0] mem_wdata;

    // Next state and memory-port drive; the port is quiet (all zero) in IDLE.
    always_comb begin
        state_d    = state_q;
        mem_enable = 1'b0;
        mem_write  = 1'b0;
        mem_addr   = 32'h0;
        mem_wdata  = '0;
        fill_en    = 1'b0;
        wb_done    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req && !hit) begin
                    state_d = (cur_valid && cur_dirty) ? WRITEBACK : ALLOCATE;
                end
            end
            WRITEBACK: begin
                mem_enable = 1'b1;
                mem_write  = 1'b1;
                mem_addr   = {cur_tag, addr_idx, {OFF_W{1'b0}}};
                mem_wdata  = cur_line;
                if (mem.mem_ack_i) begin
                    wb_done = 1'b1;
                    state_d = ALLOCATE;
                end
            end
            ALLOCATE: begin
                mem_enable = 1'b1;
                mem_addr   = {addr_tag, addr_idx, {OFF_W{1'b0}}};
                if (mem.mem_ack_i) begin
                    fill_en = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign mem.mem_enable_o = mem_enable;
    assign mem.mem_write_o  = mem_write;
    assign mem.mem_addr_o   = mem_addr;
    assign mem.mem_data_o   = mem_wdata;

    // Load data returns the pre-store word even when read and write are both set.
    assign cpu.cpu_data_o  = (req && hit) ? line_words[addr_word] : 32'h0;
    assign cpu.cpu_stall_o = (req && !hit) || (state_q != IDLE);

endmodule

// File: tb/tb_dcache_ctrl_mem.sv
// Testbench for dcache_ctrl_mem: directed scenarios followed by random
// load/store traffic, checked against a set-level cache model and a
// line-addressed memory model. The bench also plays the memory responder.

module tb_dcache_ctrl_mem;
    logic clk;
    logic rst_n;

    dcache_cpu_if                cpu_bus ();
    dcache_mem_if #(.LINE_W(256)) mem_bus ();

    dcache_ctrl_mem dut (
        .clk_i (clk),
        .rst_i (rst_n),
        .cpu   (cpu_bus),
        .mem   (mem_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total_cnt = 0;
    int bad_cnt   = 0;

    // Reference model: cache contents per set and backing memory per line address.
    bit           m_valid [16];
    bit           m_dirty [16];
    logic [22:0]  m_tag   [16];
    logic [255:0] m_line  [16];
    logic [255:0] mem_model [logic [31:0]];

    task automatic check_val(input string tag, input logic [255:0] got, input logic [255:0] exp);
        total_cnt++;
        if (got !== exp) begin
            bad_cnt++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [255:0] rand_line();
        logic [255:0] l;
        for (int i = 0; i < 8; i++) l[32*i +: 32] = $urandom;
        return l;
    endfunction

    function automatic logic [255:0] fetch_line(input logic [31:0] la);
        if (!mem_model.exists(la)) mem_model[la] = rand_line();
        return mem_model[la];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) begin
            m_valid[i] = 1'b0;
            m_dirty[i] = 1'b0;
        end
    endtask

    // One CPU access, starting and ending on a falling clock edge.
    task automatic access(input logic rd, input logic wr, input logic [31:0] addr,
                          input logic [31:0] wdata, input int lat_wb, input int lat_al,
                          input bit drop, input string tag);
        logic [3:0]   idx;
        logic [22:0]  atag;
        int           w;
        bit           hit;
        bit           evict;
        int           stalls;
        int           exp_stalls;
        logic [31:0]  la;
        logic [255:0] line;

        idx  = addr[8:5];
        atag = addr[31:9];
        w    = int'(addr[4:2]);
        cpu_bus.cpu_MemRead_i  = rd;
        cpu_bus.cpu_MemWrite_i = wr;
        cpu_bus.cpu_addr_i     = addr;
        cpu_bus.cpu_data_i     = wdata;
        #1;
        if (!(rd || wr)) begin
            check_val({tag, "_idle_stall"}, cpu_bus.cpu_stall_o, 0);
            check_val({tag, "_idle_data"}, cpu_bus.cpu_data_o, 0);
            check_val({tag, "_idle_en"}, mem_bus.mem_enable_o, 0);
            @(posedge clk); @(negedge clk);
            $display("txn %s idle addr=%08h", tag, addr);
            return;
        end
        hit = m_valid[idx] && (m_tag[idx] == atag);
        if (hit) begin
            check_val({tag, "_hit_stall"}, cpu_bus.cpu_stall_o, 0);
            check_val({tag, "_hit_data"}, cpu_bus.cpu_data_o, m_line[idx][32*w +: 32]);
            check_val({tag, "_hit_en"}, mem_bus.mem_enable_o, 0);
            if (wr) begin
                m_line[idx][32*w +: 32] = wdata;
                m_dirty[idx] = 1'b1;
            end
            @(posedge clk); @(negedge clk);
            $display("txn %s hit rd=%0b wr=%0b addr=%08h", tag, rd, wr, addr);
            return;
        end

        check_val({tag, "_miss_stall0"}, cpu_bus.cpu_stall_o, 1);
        check_val({tag, "_miss_data0"}, cpu_bus.cpu_data_o, 0);
        check_val({tag, "_miss_en0"}, mem_bus.mem_enable_o, 0);
        evict      = m_valid[idx] && m_dirty[idx];
        stalls     = 1;
        exp_stalls = 1 + lat_al + (evict ? lat_wb : 0);

        if (evict) begin
            la = {m_tag[idx], idx, 5'b0};
            for (int k = 1; k <= lat_wb; k++) begin
                @(posedge clk); @(negedge clk);
                mem_bus.mem_ack_i = 1'b0;
                #1;
                if (cpu_bus.cpu_stall_o === 1'b1) stalls++;
                check_val({tag, "_wb_en"}, mem_bus.mem_enable_o, 1);
                check_val({tag, "_wb_wr"}, mem_bus.mem_write_o, 1);
                check_val({tag, "_wb_addr"}, mem_bus.mem_addr_o, la);
                check_val({tag, "_wb_data"}, mem_bus.mem_data_o, m_line[idx]);
                if (k == lat_wb) mem_bus.mem_ack_i = 1'b1;
            end
            mem_model[la] = m_line[idx];
            m_dirty[idx]  = 1'b0;
        end

        la   = {atag, idx, 5'b0};
        line = fetch_line(la);
        for (int k = 1; k <= lat_al; k++) begin
            @(posedge clk); @(negedge clk);
            mem_bus.mem_ack_i = 1'b0;
            #1;
            if (cpu_bus.cpu_stall_o === 1'b1) stalls++;
            check_val({tag, "_al_en"}, mem_bus.mem_enable_o, 1);
            check_val({tag, "_al_wr"}, mem_bus.mem_write_o, 0);
            check_val({tag, "_al_addr"}, mem_bus.mem_addr_o, la);
            if (drop && k == 1) begin
                cpu_bus.cpu_MemRead_i  = 1'b0;
                cpu_bus.cpu_MemWrite_i = 1'b0;
            end
            if (k == lat_al) begin
                mem_bus.mem_ack_i  = 1'b1;
                mem_bus.mem_data_i = line;
            end
        end
        @(posedge clk); @(negedge clk);
        mem_bus.mem_ack_i  = 1'b0;
        mem_bus.mem_data_i = rand_line();
        #1;
        m_valid[idx] = 1'b1;
        m_dirty[idx] = 1'b0;
        m_tag[idx]   = atag;
        m_line[idx]  = line;
        check_val({tag, "_done_stall"}, cpu_bus.cpu_stall_o, 0);
        check_val({tag, "_done_en"}, mem_bus.mem_enable_o, 0);
        check_val({tag, "_stall_len"}, stalls, exp_stalls);
        if (drop) begin
            check_val({tag, "_drop_data"}, cpu_bus.cpu_data_o, 0);
        end else begin
            check_val({tag, "_fill_data"}, cpu_bus.cpu_data_o, line[32*w +: 32]);
            if (wr) begin
                m_line[idx][32*w +: 32] = wdata;
                m_dirty[idx] = 1'b1;
            end
        end
        @(posedge clk); @(negedge clk);
        $display("txn %s miss rd=%0b wr=%0b addr=%08h evict=%0b stalls=%0d", tag, rd, wr, addr, evict, stalls);
    endtask

    initial begin
        logic [255:0] l40;
        logic [31:0]  raddr;
        int           op;

        rst_n                  = 1'b0;
        cpu_bus.cpu_MemRead_i  = 1'b0;
        cpu_bus.cpu_MemWrite_i = 1'b0;
        cpu_bus.cpu_addr_i     = 32'h0;
        cpu_bus.cpu_data_i     = 32'h0;
        mem_bus.mem_ack_i      = 1'b0;
        mem_bus.mem_data_i     = '0;
        model_reset();

        repeat (2) @(negedge clk);
        #1;
        check_val("rst_en", mem_bus.mem_enable_o, 0);
        check_val("rst_wr", mem_bus.mem_write_o, 0);
        check_val("rst_addr", mem_bus.mem_addr_o, 0);
        check_val("rst_mdata", mem_bus.mem_data_o, 0);
        check_val("rst_stall", cpu_bus.cpu_stall_o, 0);
        check_val("rst_data", cpu_bus.cpu_data_o, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); @(negedge clk);

        // Cold load with a known refill line.
        l40 = rand_line();
        l40[63:32] = 32'hDEAD_BEEF;
        mem_model[32'h40] = l40;
        access(1, 0, 32'h44, 32'h0, 1, 10, 0, "cold_ld");
        access(0, 1, 32'h48, 32'h1234_5678, 1, 1, 0, "st_hit");
        access(1, 0, 32'h48, 32'h0, 1, 1, 0, "ld_after_st");

        // mem_ack_i must be ignored while idle.
        cpu_bus.cpu_MemRead_i  = 1'b0;
        cpu_bus.cpu_MemWrite_i = 1'b0;
        mem_bus.mem_ack_i      = 1'b1;
        @(posedge clk); @(negedge clk);
        mem_bus.mem_ack_i = 1'b0;
        #1;
        check_val("idle_ack_en", mem_bus.mem_enable_o, 0);
        check_val("idle_ack_stall", cpu_bus.cpu_stall_o, 0);
        @(posedge clk); @(negedge clk);

        // Dirty conflict on set 2, then come back and read+write together.
        access(1, 0, 32'h240, 32'h0, 3, 4, 0, "dirty_conf");
        check_val("wb_word2_mem", mem_model[32'h40][95:64], 32'h1234_5678);
        access(1, 0, 32'h240, 32'h0, 1, 1, 0, "conf_hit");
        access(1, 0, 32'h44, 32'h0, 2, 2, 0, "reload_44");
        access(1, 1, 32'h44, 32'hA5A5_A5A5, 1, 1, 0, "rdwr_hit");
        access(1, 0, 32'h44, 32'h0, 1, 1, 0, "rdwr_chk");

        // Request dropped in the middle of a refill; the line still lands.
        access(1, 0, 32'h520, 32'h0, 1, 4, 1, "drop");
        access(1, 0, 32'h524, 32'h0, 1, 1, 0, "drop_hit");

        // Reset asserted while a refill is outstanding.
        cpu_bus.cpu_MemRead_i = 1'b1;
        cpu_bus.cpu_addr_i    = 32'h300;
        #1;
        check_val("arst_miss_stall", cpu_bus.cpu_stall_o, 1);
        @(posedge clk); @(negedge clk);
        #1;
        check_val("arst_al_en", mem_bus.mem_enable_o, 1);
        check_val("arst_al_addr", mem_bus.mem_addr_o, 32'h300);
        #1;
        rst_n = 1'b0;
        #1;
        check_val("arst_en", mem_bus.mem_enable_o, 0);
        check_val("arst_addr", mem_bus.mem_addr_o, 0);
        check_val("arst_wr", mem_bus.mem_write_o, 0);
        cpu_bus.cpu_MemRead_i = 1'b0;
        #1;
        check_val("arst_stall", cpu_bus.cpu_stall_o, 0);
        check_val("arst_data", cpu_bus.cpu_data_o, 0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        @(posedge clk); @(negedge clk);
        access(1, 0, 32'h40, 32'h0, 1, 3, 0, "post_rst_ld");

        // Random traffic over a few sets and tags to force hits, misses and evictions.
        for (int n = 0; n < 300; n++) begin
            raddr = {21'h0, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
                     3'($urandom_range(0, 7)), 2'b00};
            op = $urandom_range(0, 3);
            access(op[0] || (op == 0 ? 1'b0 : 1'b0), op[1], raddr, $urandom,
                   $urandom_range(1, 4), $urandom_range(1, 4),
                   ($urandom_range(0, 9) == 0), "rnd");
        end

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
